// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide sequencer owning the HI/LO pair.
// A shift-add multiplier and a restoring divider share one accumulator and one
// shift register. Each operation takes WIDTH CALC edges plus one SIGN edge.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    // acc_q: upper product half (multiply) or partial remainder (divide).
    // q_q:   multiplier shifting out LSB-first, or dividend shifting out
    //        MSB-first while quotient bits shift in.
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_a_q, neg_b_q, div_q, done_q;

    logic [WIDTH-1:0]   rs_mag_d, rt_mag_d;
    logic [WIDTH:0]     mul_sum_d, div_sh_d;
    logic               div_ge_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   rem_d, quo_d;

    // Operand magnitudes, one iteration step of each unit, and the sign fixup.
    always_comb begin
        rs_mag_d  = (!md_op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag_d  = (!md_op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        mul_sum_d = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
        div_sh_d  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_ge_d  = (div_sh_d >= {1'b0, m_q});
        prod_d    = {acc_q[WIDTH-1:0], q_q};
        if (neg_a_q ^ neg_b_q)
            prod_d = -prod_d;
        // Remainder follows the dividend sign. With a zero divisor the whole
        // dividend lands in the remainder, so HI returns the original rs_data.
        rem_d = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (m_q == '0)
            quo_d = '1;
        else if (neg_a_q ^ neg_b_q)
            quo_d = -q_q;
        else
            quo_d = q_q;
    end

    // Sequencer FSM with datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= rs_data;
                    if (mtlo) lo_q <= rs_data;
                    if (start) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        div_q   <= md_op[1];
                        neg_a_q <= !md_op[0] && rs_data[WIDTH-1];
                        neg_b_q <= !md_op[0] && rt_data[WIDTH-1];
                        if (md_op[1]) begin
                            m_q <= rt_mag_d;
                            q_q <= rs_mag_d;
                        end else begin
                            m_q <= rs_mag_d;
                            q_q <= rt_mag_d;
                        end
                    end
                end
                CALC: begin
                    if (div_q) begin
                        acc_q <= div_ge_d ? (div_sh_d - {1'b0, m_q}) : div_sh_d;
                        q_q   <= {q_q[WIDTH-2:0], div_ge_d};
                    end else begin
                        acc_q <= {1'b0, mul_sum_d[WIDTH:1]};
                        q_q   <= {mul_sum_d[0], q_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1))
                        state_q <= SIGN;
                end
                SIGN: begin
                    if (div_q) begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end else begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH = 32).
module tb_md_unit;

    logic        clk, rst, start, mthi, mtlo, busy, done;
    logic [1:0]  md_op;
    logic [31:0] rs_data, rt_data, hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    int lat, bcnt, extra;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Launch one op; optionally disturb with start+mthi at loop index dis_at.
    // lat = edges from the start cycle until done is seen high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dis_at, output int lat_o, output int bcnt_o);
        int n;
        n = 0;
        bcnt_o = 0;
        @(negedge clk);
        md_op = op; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin
            if (busy) bcnt_o++;
            n++;
            if (n == dis_at) begin
                start = 1'b1; mthi = 1'b1; md_op = 2'b01;
                rs_data = 32'hDEAD; rt_data = 32'h7;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
        if (n >= 100) chk("done_timeout", 64'(n), 64'd33);
        lat_o = n + 1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        md_op = 2'b00; rs_data = '0; rt_data = '0;
        #12;
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b0;

        // MULTU max x max, with latency and busy length
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bcnt);
        chk("multu_hi", 64'(hi_o), 64'hFFFFFFFE);
        chk("multu_lo", 64'(lo_o), 64'h00000001);
        chk("multu_lat", 64'(lat), 64'd34);
        chk("multu_busy", 64'(bcnt), 64'd33);
        @(negedge clk);
        chk("done_1cyc", 64'(done), 64'd0);

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, -1, lat, bcnt);
        chk("mult_neg_hi", 64'(hi_o), 64'hFFFFFFFF);
        chk("mult_neg_lo", 64'(lo_o), 64'hFFFFFFF1);
        run_op(2'b00, 32'h80000000, 32'h80000000, -1, lat, bcnt);
        chk("mult_min_hi", 64'(hi_o), 64'h40000000);
        chk("mult_min_lo", 64'(lo_o), 64'h0);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, lat, bcnt);
        chk("div_neg_lo", 64'(lo_o), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(hi_o), 64'hFFFFFFFF);
        chk("div_lat", 64'(lat), 64'd34);
        run_op(2'b11, 32'd7, 32'd2, -1, lat, bcnt);
        chk("divu_lo", 64'(lo_o), 64'd3);
        chk("divu_hi", 64'(hi_o), 64'd1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, lat, bcnt);
        chk("div_ovf_lo", 64'(lo_o), 64'h80000000);
        chk("div_ovf_hi", 64'(hi_o), 64'h0);

        run_op(2'b11, 32'd100, 32'd0, -1, lat, bcnt);
        chk("divu0_hi", 64'(hi_o), 64'd100);
        chk("divu0_lo", 64'(lo_o), 64'hFFFFFFFF);
        run_op(2'b10, 32'hFFFFFFFB, 32'd0, -1, lat, bcnt);
        chk("div0_hi", 64'(hi_o), 64'hFFFFFFFB);
        chk("div0_lo", 64'(lo_o), 64'hFFFFFFFF);
        chk("div0_lat", 64'(lat), 64'd34);

        // start and mthi during CALC must be ignored
        run_op(2'b01, 32'd2, 32'd3, 10, lat, bcnt);
        chk("busy_ign_hi", 64'(hi_o), 64'd0);
        chk("busy_ign_lo", 64'(lo_o), 64'd6);
        chk("busy_ign_lat", 64'(lat), 64'd34);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("busy_ign_no2nd", 64'(extra), 64'd0);

        // mtlo in IDLE, then reset in the middle of a DIVU
        @(negedge clk); mtlo = 1'b1; rs_data = 32'h1234;
        @(negedge clk); mtlo = 1'b0;
        chk("mtlo_write", 64'(lo_o), 64'h1234);
        md_op = 2'b11; rs_data = 32'd9; rt_data = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_hi", 64'(hi_o), 64'd0);
        chk("rst_mid_lo", 64'(lo_o), 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(2'b01, 32'd4, 32'd4, -1, lat, bcnt);
        chk("post_rst_lo", 64'(lo_o), 64'd16);
        chk("post_rst_hi", 64'(hi_o), 64'd0);
        chk("post_rst_lat", 64'(lat), 64'd34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
